// File: rtl/fa_cache_pkg.sv
// Shared memory-subsystem definitions: default bus widths, the cache line
// record layout and a helper for sizing line-index fields.
package fa_cache_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    // One cache line: valid bit, full-address tag, one data word.
    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_DEF-1:0] tag;
        logic [DATA_W_DEF-1:0] data;
    } line_t;

    // Width of a line index; at least one bit so a single-line cache still
    // has a legal index type.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fa_cache_if.sv
// Lookup/fill/eviction bus of the fully associative cache.
// Handshake: re and we are single-cycle strobes sampled on the rising edge of
// clk with no backpressure; hit/rdata and evicted_* are registered results of
// that same edge and are held for exactly one cycle. The evicted_* group
// carries the same meaning as waddr/wdata/we, so an instance can feed the next
// cache level directly.
interface fa_cache_if
    import fa_cache_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [ADDR_W-1:0] raddr;
    logic              re;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic [DATA_W-1:0] rdata;
    logic              hit;
    logic [ADDR_W-1:0] evicted_addr;
    logic [DATA_W-1:0] evicted_data;
    logic              evicted_valid;

    modport master (
        output raddr, re, waddr, wdata, we,
        input  rdata, hit, evicted_addr, evicted_data, evicted_valid
    );

    modport slave (
        input  raddr, re, waddr, wdata, we,
        output rdata, hit, evicted_addr, evicted_data, evicted_valid
    );
endinterface

// File: rtl/fa_cache_lru_tracker.sv
// True-LRU order tracker. Each line carries an age rank: 0 is LRU,
// N_ENTRIES-1 is MRU; the ranks always form a permutation. A read touch is
// applied before a write touch, so the written line ends up MRU and the read
// line second-most-recent when both occur in one cycle. The victim reflects
// the order before this cycle's touches.
module lru_tracker
    import fa_cache_pkg::*;
#(
    parameter  int N_ENTRIES = 4,
    localparam int IDX_W     = idx_width(N_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_touch,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic             wr_touch,
    input  logic [IDX_W-1:0] wr_idx,
    output logic [IDX_W-1:0] victim
);

    typedef logic [N_ENTRIES-1:0][IDX_W-1:0] age_t;

    age_t age_q;
    age_t age_after_rd;
    age_t age_next;

    // Move one line to MRU; every line that was more recent slides down one.
    function automatic age_t promote(input age_t a, input logic [IDX_W-1:0] idx);
        age_t r;
        r = a;
        for (int j = 0; j < N_ENTRIES; j++) begin
            if (a[j] > a[idx]) r[j] = a[j] - 1'b1;
        end
        r[idx] = IDX_W'(N_ENTRIES - 1);
        return r;
    endfunction

    // Apply read touch first, then write touch.
    always_comb begin
        age_after_rd = rd_touch ? promote(age_q, rd_idx) : age_q;
        age_next     = wr_touch ? promote(age_after_rd, wr_idx) : age_after_rd;
    end

    // Victim is whichever line currently holds rank 0.
    always_comb begin
        victim = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (age_q[i] == '0) victim = IDX_W'(i);
        end
    end

    // Rank register; reset puts line 0 at LRU, highest index at MRU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENTRIES; i++) age_q[i] <= IDX_W'(i);
        end else begin
            age_q <= age_next;
        end
    end

endmodule

// File: rtl/fa_cache.sv
// Fully associative cache with true-LRU replacement. Lookups read pre-write
// contents except when re and we name the same address, in which case the
// write data is bypassed. Fills update in place, then take the lowest free
// line, then displace the LRU line and report it on evicted_*.
module fa_cache
    import fa_cache_pkg::*;
#(
    parameter  int N_ENTRIES = 4,
    parameter  int ADDR_W    = ADDR_W_DEF,
    parameter  int DATA_W    = DATA_W_DEF,
    localparam int IDX_W     = idx_width(N_ENTRIES)
) (
    input logic       clk,
    input logic       rst_n,
    fa_cache_if.slave bus
);

    // Line storage, split per field of the line record so widths follow the
    // instance parameters.
    logic [N_ENTRIES-1:0] valid_q;
    logic [ADDR_W-1:0]    tag_q  [N_ENTRIES];
    logic [DATA_W-1:0]    data_q [N_ENTRIES];

    logic             rd_hit;
    logic [IDX_W-1:0] rd_idx;
    logic             wr_hit;
    logic [IDX_W-1:0] wr_hit_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] victim;
    logic [IDX_W-1:0] wr_idx;
    logic             evict;
    logic             bypass;

    logic              hit_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ev_valid_q;
    logic [ADDR_W-1:0] ev_addr_q;
    logic [DATA_W-1:0] ev_data_q;

    // Tag match for both ports and lowest-index free line search.
    always_comb begin
        rd_hit     = 1'b0;
        rd_idx     = '0;
        wr_hit     = 1'b0;
        wr_hit_idx = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == bus.raddr) begin
                rd_hit = 1'b1;
                rd_idx = IDX_W'(i);
            end
            if (valid_q[i] && tag_q[i] == bus.waddr) begin
                wr_hit     = 1'b1;
                wr_hit_idx = IDX_W'(i);
            end
            if (!free_found && !valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Fill target selection: update in place, else free line, else LRU.
    always_comb begin
        wr_idx = wr_hit ? wr_hit_idx : (free_found ? free_idx : victim);
        evict  = bus.we && !wr_hit && !free_found;
        bypass = bus.re && bus.we && (bus.raddr == bus.waddr);
    end

    lru_tracker #(.N_ENTRIES(N_ENTRIES)) u_lru (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_touch (bus.re && rd_hit),
        .rd_idx   (rd_idx),
        .wr_touch (bus.we),
        .wr_idx   (wr_idx),
        .victim   (victim)
    );

    // Line array update on fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (bus.we) begin
            valid_q[wr_idx] <= 1'b1;
            tag_q[wr_idx]   <= bus.waddr;
            data_q[wr_idx]  <= bus.wdata;
        end
    end

    // Registered lookup result and one-cycle eviction report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q      <= 1'b0;
            rdata_q    <= '0;
            ev_valid_q <= 1'b0;
            ev_addr_q  <= '0;
            ev_data_q  <= '0;
        end else begin
            if (bypass) begin
                hit_q   <= 1'b1;
                rdata_q <= bus.wdata;
            end else if (bus.re && rd_hit) begin
                hit_q   <= 1'b1;
                rdata_q <= data_q[rd_idx];
            end else begin
                hit_q   <= 1'b0;
                rdata_q <= '0;
            end
            ev_valid_q <= evict;
            ev_addr_q  <= evict ? tag_q[victim]  : '0;
            ev_data_q  <= evict ? data_q[victim] : '0;
        end
    end

    assign bus.hit           = hit_q;
    assign bus.rdata         = rdata_q;
    assign bus.evicted_valid = ev_valid_q;
    assign bus.evicted_addr  = ev_addr_q;
    assign bus.evicted_data  = ev_data_q;

endmodule

// File: tb/tb_fa_cache.sv
// Directed bench for fa_cache: each step drives one cycle of stimulus on the
// falling edge, pushes the expected registered outputs, and compares them
// just after the following rising edge.
module tb_fa_cache;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int W  = 1 + DW + 1 + AW + DW;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [W-1:0] exp_q[$];

    fa_cache_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    fa_cache #(.N_ENTRIES(4), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare the DUT outputs against the oldest expected entry.
    task automatic check_outputs(input string tag);
        logic [W-1:0]  e;
        logic          e_hit;
        logic [DW-1:0] e_rdata;
        logic          e_ev;
        logic [AW-1:0] e_ea;
        logic [DW-1:0] e_ed;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = exp_q.pop_front();
        {e_hit, e_rdata, e_ev, e_ea, e_ed} = e;
        checks++;
        assert ({bus.hit, bus.rdata} === {e_hit, e_rdata}) else begin
            errors++;
            $error("FAIL %s lookup: got hit=%b rdata=%h expected hit=%b rdata=%h",
                   tag, bus.hit, bus.rdata, e_hit, e_rdata);
        end
        checks++;
        assert ({bus.evicted_valid, bus.evicted_addr, bus.evicted_data} === {e_ev, e_ea, e_ed}) else begin
            errors++;
            $error("FAIL %s evict: got v=%b a=%h d=%h expected v=%b a=%h d=%h", tag,
                   bus.evicted_valid, bus.evicted_addr, bus.evicted_data, e_ev, e_ea, e_ed);
        end
    endtask

    // One clock of stimulus with its expected registered outputs.
    task automatic step(input logic r, input logic [AW-1:0] ra,
                        input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic eh, input logic [DW-1:0] erd,
                        input logic eev, input logic [AW-1:0] eea, input logic [DW-1:0] eed,
                        input string tag);
        @(negedge clk);
        bus.re    = r;
        bus.raddr = ra;
        bus.we    = w;
        bus.waddr = wa;
        bus.wdata = wd;
        exp_q.push_back({eh, erd, eev, eea, eed});
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic eh, input logic [DW-1:0] erd,
                      input string tag);
        step(1'b1, a, 1'b0, $urandom_range(0, 16'hffff), $urandom_range(0, 16'hffff),
             eh, erd, 1'b0, '0, '0, tag);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic eev, input logic [AW-1:0] eea, input logic [DW-1:0] eed,
                      input string tag);
        step(1'b0, $urandom_range(0, 16'hffff), 1'b1, a, d, 1'b0, '0, eev, eea, eed, tag);
    endtask

    // Assert reset right now, check outputs clear without a clock edge,
    // then release on a falling edge.
    task automatic apply_reset(input string tag);
        rst_n  = 1'b0;
        bus.re = 1'b0;
        bus.we = 1'b0;
        exp_q.push_back('0);
        #1;
        check_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.re    = 1'b0;
        bus.we    = 1'b0;
        bus.raddr = '0;
        bus.waddr = '0;
        bus.wdata = '0;
        repeat (2) @(negedge clk);
        apply_reset("reset");

        // Empty cache misses; fill then hit.
        rd(16'h0010, 1'b0, 16'h0000, "empty_miss");
        wr(16'h0010, 16'hAAAA, 1'b0, '0, '0, "first_fill");
        rd(16'h0010, 1'b1, 16'hAAAA, "first_hit");

        // LRU eviction after a read refreshes line 0.
        @(negedge clk);
        apply_reset("reset2");
        wr(16'h0001, 16'h1111, 1'b0, '0, '0, "fill1");
        wr(16'h0002, 16'h2222, 1'b0, '0, '0, "fill2");
        wr(16'h0003, 16'h3333, 1'b0, '0, '0, "fill3");
        wr(16'h0004, 16'h4444, 1'b0, '0, '0, "fill4");
        rd(16'h0001, 1'b1, 16'h1111, "touch1");
        wr(16'h0005, 16'h5555, 1'b1, 16'h0002, 16'h2222, "evict2");
        rd(16'h0002, 1'b0, 16'h0000, "evicted_miss");

        // In-place update without eviction.
        wr(16'h0003, 16'hBEEF, 1'b0, '0, '0, "update3");
        rd(16'h0003, 1'b1, 16'hBEEF, "update3_read");

        // Read of the line being evicted in the same cycle sees old data.
        step(1'b1, 16'h0004, 1'b1, 16'h0006, 16'h6666,
             1'b1, 16'h4444, 1'b1, 16'h0004, 16'h4444, "read_victim");

        // Read hit of 0x0005 with write to 0x0001: 0x0001 MRU, 0x0005 next.
        step(1'b1, 16'h0005, 1'b1, 16'h0001, 16'h1234,
             1'b1, 16'h5555, 1'b0, '0, '0, "dual_touch");
        wr(16'h0007, 16'h7070, 1'b1, 16'h0003, 16'hBEEF, "evict3");
        wr(16'h0008, 16'h8080, 1'b1, 16'h0006, 16'h6666, "evict6");
        wr(16'h0009, 16'h9090, 1'b1, 16'h0005, 16'h5555, "evict5");
        rd(16'h0001, 1'b1, 16'h1234, "mru_kept");

        // re=0 / we=0 ignore their address and data.
        step(1'b0, 16'h0009, 1'b0, 16'h0009, 16'hDEAD,
             1'b0, 16'h0000, 1'b0, '0, '0, "idle_ignored");
        rd(16'h0009, 1'b1, 16'h9090, "idle_no_write");

        // Same-address read and write: bypass.
        @(negedge clk);
        apply_reset("reset3");
        step(1'b1, 16'h0007, 1'b1, 16'h0007, 16'h7777,
             1'b1, 16'h7777, 1'b0, '0, '0, "bypass");
        rd(16'h0007, 1'b1, 16'h7777, "bypass_stored");

        // Async reset mid-cycle from a full cache with live outputs.
        @(negedge clk);
        apply_reset("reset4");
        for (int i = 1; i <= 4; i++) begin
            wr(AW'(i), DW'(i * 16'h1111), 1'b0, '0, '0, "refill");
        end
        step(1'b1, 16'h0002, 1'b1, 16'h0005, 16'h5555,
             1'b1, 16'h2222, 1'b1, 16'h0001, 16'h1111, "pre_reset");
        #2;
        apply_reset("async_reset");
        for (int i = 1; i <= 5; i++) begin
            rd(AW'(i), 1'b0, 16'h0000, "post_reset_miss");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
